// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state encodings,
// opcode constants, ALU select bit positions and operation classes.
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_SHR  = 5'b00111;
    localparam logic [4:0] OPC_SHL  = 5'b01000;
    localparam logic [4:0] OPC_ROR  = 5'b01001;
    localparam logic [4:0] OPC_ROL  = 5'b01010;
    localparam logic [4:0] OPC_MUL  = 5'b01111;
    localparam logic [4:0] OPC_DIV  = 5'b10000;
    localparam logic [4:0] OPC_NEG  = 5'b10001;
    localparam logic [4:0] OPC_NOT  = 5'b10010;
    localparam logic [4:0] OPC_NOP  = 5'b11000;
    localparam logic [4:0] OPC_HALT = 5'b11001;

    // Bit positions inside the one-hot alu_sel vector (bit 0 = ADD).
    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_MUL = 2;
    localparam int ALU_DIV = 3;
    localparam int ALU_SHR = 4;
    localparam int ALU_SHL = 5;
    localparam int ALU_ROR = 6;
    localparam int ALU_ROL = 7;
    localparam int ALU_AND = 8;
    localparam int ALU_OR  = 9;
    localparam int ALU_NEG = 10;
    localparam int ALU_NOT = 11;

    localparam int ALU_W = 12;

    // How an instruction walks through T3..T6. Undefined opcodes are
    // classed as NOP; the decoder flags them separately.
    typedef enum logic [2:0] {
        CLS_ALU3   = 3'd0,
        CLS_MULDIV = 3'd1,
        CLS_UNARY  = 3'd2,
        CLS_NOP    = 3'd3,
        CLS_HALT   = 3'd4
    } op_class_t;

endpackage

// File: rtl/control_sequencer_ir_decode.sv
// Purely combinational instruction decoder: classifies the opcode, builds
// the ALU select, and turns the Ra/Rb/Rc fields into one-hot selects.
module ir_decode
    import control_sequencer_pkg::*;
(
    input  logic [31:0]      ir,
    output op_class_t        op_class,
    output logic [ALU_W-1:0] alu_sel,
    output logic [15:0]      ra_sel,
    output logic [15:0]      rb_sel,
    output logic [15:0]      rc_sel,
    output logic             illegal
);

    logic [4:0] opcode;
    logic       unused_ir_bits;

    assign opcode         = ir[31:27];
    assign unused_ir_bits = ^ir[14:0];

    assign ra_sel = 16'b1 << ir[26:23];
    assign rb_sel = 16'b1 << ir[22:19];
    assign rc_sel = 16'b1 << ir[18:15];

    // Map each opcode to its class and ALU operation; anything unlisted is illegal.
    always_comb begin
        op_class = CLS_NOP;
        alu_sel  = '0;
        illegal  = 1'b0;
        case (opcode)
            OPC_ADD:  begin op_class = CLS_ALU3;   alu_sel[ALU_ADD] = 1'b1; end
            OPC_SUB:  begin op_class = CLS_ALU3;   alu_sel[ALU_SUB] = 1'b1; end
            OPC_AND:  begin op_class = CLS_ALU3;   alu_sel[ALU_AND] = 1'b1; end
            OPC_OR:   begin op_class = CLS_ALU3;   alu_sel[ALU_OR]  = 1'b1; end
            OPC_SHR:  begin op_class = CLS_ALU3;   alu_sel[ALU_SHR] = 1'b1; end
            OPC_SHL:  begin op_class = CLS_ALU3;   alu_sel[ALU_SHL] = 1'b1; end
            OPC_ROR:  begin op_class = CLS_ALU3;   alu_sel[ALU_ROR] = 1'b1; end
            OPC_ROL:  begin op_class = CLS_ALU3;   alu_sel[ALU_ROL] = 1'b1; end
            OPC_MUL:  begin op_class = CLS_MULDIV; alu_sel[ALU_MUL] = 1'b1; end
            OPC_DIV:  begin op_class = CLS_MULDIV; alu_sel[ALU_DIV] = 1'b1; end
            OPC_NEG:  begin op_class = CLS_UNARY;  alu_sel[ALU_NEG] = 1'b1; end
            OPC_NOT:  begin op_class = CLS_UNARY;  alu_sel[ALU_NOT] = 1'b1; end
            OPC_NOP:  op_class = CLS_NOP;
            OPC_HALT: op_class = CLS_HALT;
            default:  illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer for a simple bus-based CPU datapath. A single state
// register walks fetch (T0-T2) and execute (T3-T6); every strobe is a
// Moore function of the current state and the instruction register.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    input  logic             stop,
    output logic             read,
    output logic             pc_out,
    output logic             mar_in,
    output logic             inc_pc,
    output logic             z_in,
    output logic             zlow_out,
    output logic             zhigh_out,
    output logic             pc_in,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             ir_in,
    output logic             y_in,
    output logic             lo_in,
    output logic             hi_in,
    output logic [ALU_W-1:0] alu_sel,
    output logic [15:0]      reg_in,
    output logic [15:0]      reg_out,
    output logic             run,
    output logic             illegal,
    output logic [3:0]       state
);

    state_t            state_q;
    op_class_t         dec_class;
    logic [ALU_W-1:0]  dec_alu;
    logic [15:0]       dec_ra;
    logic [15:0]       dec_rb;
    logic [15:0]       dec_rc;
    logic              dec_illegal;

    ir_decode u_ir_decode (
        .ir       (ir),
        .op_class (dec_class),
        .alu_sel  (dec_alu),
        .ra_sel   (dec_ra),
        .rb_sel   (dec_rb),
        .rc_sel   (dec_rc),
        .illegal  (dec_illegal)
    );

    // State register and transitions; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_q <= stop ? ST_IDLE : ST_T0;
                ST_T0:   state_q <= ST_T1;
                ST_T1:   state_q <= mem_ready ? ST_T2 : ST_T1;
                ST_T2:   state_q <= ST_T3;
                ST_T3: begin
                    case (dec_class)
                        CLS_ALU3, CLS_MULDIV, CLS_UNARY: state_q <= ST_T4;
                        CLS_HALT:                        state_q <= ST_HALT;
                        default:                         state_q <= stop ? ST_IDLE : ST_T0;
                    endcase
                end
                ST_T4:   state_q <= ST_T5;
                ST_T5: begin
                    if (dec_class == CLS_MULDIV)
                        state_q <= ST_T6;
                    else
                        state_q <= stop ? ST_IDLE : ST_T0;
                end
                ST_T6:   state_q <= stop ? ST_IDLE : ST_T0;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobe decode from the current state; NOP, HALT and illegal ops never reach T4.
    always_comb begin
        read      = 1'b0;
        pc_out    = 1'b0;
        mar_in    = 1'b0;
        inc_pc    = 1'b0;
        z_in      = 1'b0;
        zlow_out  = 1'b0;
        zhigh_out = 1'b0;
        pc_in     = 1'b0;
        mdr_in    = 1'b0;
        mdr_out   = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        lo_in     = 1'b0;
        hi_in     = 1'b0;
        alu_sel   = '0;
        reg_in    = '0;
        reg_out   = '0;
        case (state_q)
            ST_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            ST_T1: begin
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                read     = 1'b1;
                mdr_in   = 1'b1;
            end
            ST_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            ST_T3: begin
                if (dec_class == CLS_ALU3 || dec_class == CLS_MULDIV) begin
                    reg_out = dec_rb;
                    y_in    = 1'b1;
                end
            end
            ST_T4: begin
                z_in    = 1'b1;
                alu_sel = dec_alu;
                reg_out = (dec_class == CLS_UNARY) ? dec_rb : dec_rc;
            end
            ST_T5: begin
                zlow_out = 1'b1;
                if (dec_class == CLS_MULDIV)
                    lo_in = 1'b1;
                else
                    reg_in = dec_ra;
            end
            ST_T6: begin
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = (state_q == ST_T3) && dec_illegal;
    assign run     = (state_q != ST_HALT);
    assign state   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: hand-computed expectations for
// ADD, MUL, NEG with a memory stall, an illegal opcode, stop, reset and HALT.
module tb_control_sequencer;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    // Packed strobe vector bit values, order {read..hi_in}.
    localparam logic [13:0] B_READ   = 14'h2000;
    localparam logic [13:0] B_PCOUT  = 14'h1000;
    localparam logic [13:0] B_MARIN  = 14'h0800;
    localparam logic [13:0] B_INCPC  = 14'h0400;
    localparam logic [13:0] B_ZIN    = 14'h0200;
    localparam logic [13:0] B_ZLOW   = 14'h0100;
    localparam logic [13:0] B_ZHIGH  = 14'h0080;
    localparam logic [13:0] B_PCIN   = 14'h0040;
    localparam logic [13:0] B_MDRIN  = 14'h0020;
    localparam logic [13:0] B_MDROUT = 14'h0010;
    localparam logic [13:0] B_IRIN   = 14'h0008;
    localparam logic [13:0] B_YIN    = 14'h0004;
    localparam logic [13:0] B_LOIN   = 14'h0002;
    localparam logic [13:0] B_HIIN   = 14'h0001;

    localparam logic [13:0] STB_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [13:0] STB_T1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
    localparam logic [13:0] STB_T2 = B_MDROUT | B_IRIN;

    localparam logic [31:0] IR_ADD  = 32'h1891_8000;
    localparam logic [31:0] IR_MUL  = 32'h7822_8000;
    localparam logic [31:0] IR_NEG  = 32'h8B38_0000;
    localparam logic [31:0] IR_ILL  = 32'hF800_0000;
    localparam logic [31:0] IR_NOP  = 32'hC000_0000;
    localparam logic [31:0] IR_HALT = 32'hC800_0000;

    logic        clk;
    logic        reset;
    logic [31:0] ir;
    logic        mem_ready;
    logic        stop;
    logic        read, pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out;
    logic        pc_in, mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in;
    logic [11:0] alu_sel;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic        run;
    logic        illegal;
    logic [3:0]  state;
    logic [13:0] strobes;

    int tests_run;
    int tests_failed;

    control_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .ir        (ir),
        .mem_ready (mem_ready),
        .stop      (stop),
        .read      (read),
        .pc_out    (pc_out),
        .mar_in    (mar_in),
        .inc_pc    (inc_pc),
        .z_in      (z_in),
        .zlow_out  (zlow_out),
        .zhigh_out (zhigh_out),
        .pc_in     (pc_in),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out),
        .ir_in     (ir_in),
        .y_in      (y_in),
        .lo_in     (lo_in),
        .hi_in     (hi_in),
        .alu_sel   (alu_sel),
        .reg_in    (reg_in),
        .reg_out   (reg_out),
        .run       (run),
        .illegal   (illegal),
        .state     (state)
    );

    assign strobes = {read, pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out,
                      pc_in, mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in};

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] new_ir, input logic new_stop,
                                 input logic new_ready);
        ir        = new_ir;
        stop      = new_stop;
        mem_ready = new_ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCycle(input string tag, input logic [3:0] exp_state,
                              input logic [13:0] exp_strobes, input logic [15:0] exp_reg_in,
                              input logic [15:0] exp_reg_out, input logic [11:0] exp_alu);
        checkOutput({tag, ".state"},   32'(state),   32'(exp_state));
        checkOutput({tag, ".strobes"}, 32'(strobes), 32'(exp_strobes));
        checkOutput({tag, ".reg_in"},  32'(reg_in),  32'(exp_reg_in));
        checkOutput({tag, ".reg_out"}, 32'(reg_out), 32'(exp_reg_out));
        checkOutput({tag, ".alu_sel"}, 32'(alu_sel), 32'(exp_alu));
    endtask

    // From T0 with mem_ready=1, step through and check T1 and T2.
    task automatic fetch(input string tag);
        tick();
        checkCycle({tag, ".t1"}, S_T1, STB_T1, 16'h0, 16'h0, 12'h0);
        tick();
        checkCycle({tag, ".t2"}, S_T2, STB_T2, 16'h0, 16'h0, 12'h0);
    endtask

    initial begin
        int pc_out_seen;
        int strobe_seen;
        int run_high_seen;
        int state_moved;

        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        applyStimulus(IR_ADD, 1'b0, 1'b1);

        repeat (3) tick();
        checkCycle("rst", S_IDLE, 14'h0, 16'h0, 16'h0, 12'h0);
        checkOutput("rst.run", 32'(run), 32'd1);
        checkOutput("rst.illegal", 32'(illegal), 32'd0);

        reset = 1'b1;
        tick();
        checkCycle("add.t0", S_T0, STB_T0, 16'h0, 16'h0, 12'h0);
        fetch("add");
        tick();
        checkCycle("add.t3", S_T3, B_YIN, 16'h0, 16'h0004, 12'h0);
        tick();
        checkCycle("add.t4", S_T4, B_ZIN, 16'h0, 16'h0008, 12'h001);
        tick();
        checkCycle("add.t5", S_T5, B_ZLOW, 16'h0002, 16'h0, 12'h0);
        tick();
        checkCycle("add.next", S_T0, STB_T0, 16'h0, 16'h0, 12'h0);

        applyStimulus(IR_MUL, 1'b0, 1'b1);
        fetch("mul");
        tick();
        checkCycle("mul.t3", S_T3, B_YIN, 16'h0, 16'h0010, 12'h0);
        tick();
        checkCycle("mul.t4", S_T4, B_ZIN, 16'h0, 16'h0020, 12'h004);
        tick();
        checkCycle("mul.t5", S_T5, B_ZLOW | B_LOIN, 16'h0, 16'h0, 12'h0);
        tick();
        checkCycle("mul.t6", S_T6, B_ZHIGH | B_HIIN, 16'h0, 16'h0, 12'h0);
        tick();
        checkCycle("mul.next", S_T0, STB_T0, 16'h0, 16'h0, 12'h0);

        // NEG R6,R7 with memory not ready for the first three T1 cycles.
        applyStimulus(IR_NEG, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkCycle($sformatf("stall.t1_%0d", i), S_T1, STB_T1, 16'h0, 16'h0, 12'h0);
        end
        mem_ready = 1'b1;
        tick();
        checkCycle("neg.t2", S_T2, STB_T2, 16'h0, 16'h0, 12'h0);
        tick();
        checkCycle("neg.t3", S_T3, 14'h0, 16'h0, 16'h0, 12'h0);
        tick();
        checkCycle("neg.t4", S_T4, B_ZIN, 16'h0, 16'h0080, 12'h400);
        tick();
        checkCycle("neg.t5", S_T5, B_ZLOW, 16'h0040, 16'h0, 12'h0);
        tick();
        checkOutput("neg.next", 32'(state), 32'(S_T0));

        applyStimulus(IR_ILL, 1'b0, 1'b1);
        checkOutput("ill.t0_flag", 32'(illegal), 32'd0);
        fetch("ill");
        checkOutput("ill.t2_flag", 32'(illegal), 32'd0);
        tick();
        checkCycle("ill.t3", S_T3, 14'h0, 16'h0, 16'h0, 12'h0);
        checkOutput("ill.t3_flag", 32'(illegal), 32'd1);
        tick();
        checkOutput("ill.next", 32'(state), 32'(S_T0));
        checkOutput("ill.after_flag", 32'(illegal), 32'd0);

        // NOP with stop raised: parks in IDLE until stop drops.
        applyStimulus(IR_NOP, 1'b1, 1'b1);
        fetch("nop");
        tick();
        checkCycle("nop.t3", S_T3, 14'h0, 16'h0, 16'h0, 12'h0);
        tick();
        checkCycle("stop.idle0", S_IDLE, 14'h0, 16'h0, 16'h0, 12'h0);
        tick();
        tick();
        checkCycle("stop.idle2", S_IDLE, 14'h0, 16'h0, 16'h0, 12'h0);
        stop = 1'b0;
        tick();
        checkOutput("stop.resume", 32'(state), 32'(S_T0));

        // Reset in the middle of T4 of an ADD.
        applyStimulus(IR_ADD, 1'b0, 1'b1);
        fetch("rst4");
        tick();
        tick();
        checkOutput("rst4.in_t4", 32'(state), 32'(S_T4));
        reset = 1'b0;
        #1;
        checkCycle("rst4.async", S_IDLE, 14'h0, 16'h0, 16'h0, 12'h0);
        checkOutput("rst4.run", 32'(run), 32'd1);
        #1;
        reset = 1'b1;
        tick();
        checkOutput("rst4.restart", 32'(state), 32'(S_T0));

        applyStimulus(IR_HALT, 1'b0, 1'b1);
        fetch("halt");
        tick();
        checkOutput("halt.t3", 32'(state), 32'(S_T3));
        tick();
        checkCycle("halt.enter", S_HALT, 14'h0, 16'h0, 16'h0, 12'h0);
        checkOutput("halt.run", 32'(run), 32'd0);
        pc_out_seen   = 0;
        strobe_seen   = 0;
        run_high_seen = 0;
        state_moved   = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pc_out)            pc_out_seen++;
            if (strobes != 14'h0)  strobe_seen++;
            if (run)               run_high_seen++;
            if (state != S_HALT)   state_moved++;
        end
        checkOutput("halt.pc_out_cycles", 32'(pc_out_seen), 32'd0);
        checkOutput("halt.strobe_cycles", 32'(strobe_seen), 32'd0);
        checkOutput("halt.run_cycles", 32'(run_high_seen), 32'd0);
        checkOutput("halt.left_state", 32'(state_moved), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("halt.rst_state", 32'(state), 32'(S_IDLE));
        checkOutput("halt.rst_run", 32'(run), 32'd1);
        #1;
        reset = 1'b1;
        tick();
        checkCycle("halt.restart", S_T0, STB_T0, 16'h0, 16'h0, 12'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
